// File: rtl/seq_bit_gen_if.sv
// -----------------------------------------------------------------------------
// seq_bit_gen_if
//   Bundle of the word handshake and serial-line signals of seq_bit_gen.
//   Parameter:
//     DATA_W    width of the parallel word
//   Signals:
//     din        word to transmit              (source -> generator)
//     din_valid  din is valid                  (source -> generator)
//     din_ready  generator accepts din         (generator -> source)
//     x_out      serial bit line, MSB first    (generator -> source/detector)
//     x_valid    x_out carries a data bit      (generator -> source/detector)
//     busy       word in SHIFT or GAP          (generator -> source)
//     done       1-cycle word-complete pulse   (generator -> source)
//   Modports:
//     master  word source side
//     slave   bit generator side
// -----------------------------------------------------------------------------
interface seq_bit_gen_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              x_out;
  logic              x_valid;
  logic              busy;
  logic              done;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  x_out,
    input  x_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output x_out,
    output x_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/seq_bit_gen.sv
// -----------------------------------------------------------------------------
// seq_bit_gen
//   Serial bit-stream generator. Accepts a parallel word over a valid/ready
//   handshake and shifts it out MSB-first, one bit per clock, on x_out. After
//   each word the line is held at 0 for GAP_CYCLES idle cycles, then a
//   one-cycle done pulse is raised in the first IDLE cycle.
//   Parameters:
//     DATA_W      width of each serialized word (>= 1)
//     GAP_CYCLES  idle cycles of x_out=0 after each word (0 = no gap)
//     CNT_W       width of edge_cnt (only with SEQ_EDGE_CNT_EN)
//   Ports:
//     clk       clock, rising edge
//     rst_n     asynchronous active-low reset
//     bus       seq_bit_gen_if.slave: din/din_valid/din_ready handshake and
//               x_out/x_valid/busy/done (all registered except din_ready)
//     edge_cnt  saturating count of 1->0 transitions on x_out
//               (only with SEQ_EDGE_CNT_EN)
//   Configuration macro:
//     SEQ_EDGE_CNT_EN  when defined, adds the edge_cnt port and its counter.
// -----------------------------------------------------------------------------
module seq_bit_gen #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
`ifdef SEQ_EDGE_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_bit_gen_if.slave       bus
`ifdef SEQ_EDGE_CNT_EN
  ,
  output logic [CNT_W-1:0]   edge_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic            HAS_GAP  = (GAP_CYCLES > 0);

  state_t            state_r,   state_s;
  logic [DATA_W-1:0] sreg_r,    sreg_s;
  logic [BC_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic [GC_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic              x_out_r,   x_out_s;
  logic              x_valid_r, x_valid_s;
  logic              busy_r,    busy_s;
  logic              done_r,    done_s;

  assign bus.din_ready = (state_r == ST_IDLE);
  assign bus.x_out     = x_out_r;
  assign bus.x_valid   = x_valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  // Next-state and next-output logic. Outputs default to the idle values
  // (line low, not valid, not busy, no done) and each state overrides them.
  // sreg holds the bits still to be sent, left-aligned; the bit going out
  // next is always its MSB, so x_out is loaded one cycle ahead from there.
  always_comb begin
    state_s   = state_r;
    sreg_s    = sreg_r;
    bit_cnt_s = bit_cnt_r;
    gap_cnt_s = gap_cnt_r;
    x_out_s   = 1'b0;
    x_valid_s = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.din_valid) begin
          state_s   = ST_SHIFT;
          x_out_s   = bus.din[DATA_W-1];
          sreg_s    = bus.din << 1'b1;
          bit_cnt_s = '0;
          x_valid_s = 1'b1;
          busy_s    = 1'b1;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_r == BIT_LAST) begin
          // Last bit is on the line this cycle; leave SHIFT next edge.
          if (HAS_GAP) begin
            state_s   = ST_GAP;
            gap_cnt_s = '0;
            busy_s    = 1'b1;
          end else begin
            state_s   = ST_IDLE;
            done_s    = 1'b1;
          end
        end else begin
          bit_cnt_s = bit_cnt_r + 1'b1;
          x_out_s   = sreg_r[DATA_W-1];
          sreg_s    = sreg_r << 1'b1;
          x_valid_s = 1'b1;
          busy_s    = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s   = ST_IDLE;
          done_s    = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r + 1'b1;
          busy_s    = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      sreg_r    <= '0;
      bit_cnt_r <= '0;
      gap_cnt_r <= '0;
      x_out_r   <= 1'b0;
      x_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      sreg_r    <= sreg_s;
      bit_cnt_r <= bit_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      x_out_r   <= x_out_s;
      x_valid_r <= x_valid_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

`ifdef SEQ_EDGE_CNT_EN
  logic             x_prev_r;
  logic [CNT_W-1:0] edge_cnt_r;

  // Falling-edge counter on x_out: compares the registered line with its
  // previous value and saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev_r   <= 1'b0;
      edge_cnt_r <= '0;
    end else begin
      x_prev_r <= x_out_r;
      if (x_prev_r && !x_out_r && (edge_cnt_r != {CNT_W{1'b1}})) begin
        edge_cnt_r <= edge_cnt_r + 1'b1;
      end
    end
  end

  assign edge_cnt = edge_cnt_r;
`endif

endmodule

// File: tb/tb_seq_bit_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_gen
//   Directed bench for seq_bit_gen. Two instances share clock and reset:
//   dut1 with GAP_CYCLES=1 and dut0 with GAP_CYCLES=0 (the latter uses a 2-bit
//   edge counter so saturation is reachable when SEQ_EDGE_CNT_EN is defined).
//   Status vectors compared below are {x_out, x_valid, busy, done, din_ready}.
// -----------------------------------------------------------------------------
module tb_seq_bit_gen;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  seq_bit_gen_if #(.DATA_W(8)) bus1 ();
  seq_bit_gen_if #(.DATA_W(8)) bus0 ();

`ifdef SEQ_EDGE_CNT_EN
  logic [15:0] ec1;
  logic [1:0]  ec0;
`endif

  seq_bit_gen #(
    .DATA_W(8),
    .GAP_CYCLES(1)
`ifdef SEQ_EDGE_CNT_EN
    ,
    .CNT_W(16)
`endif
  ) dut1 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus1.slave)
`ifdef SEQ_EDGE_CNT_EN
    ,
    .edge_cnt(ec1)
`endif
  );

  seq_bit_gen #(
    .DATA_W(8),
    .GAP_CYCLES(0)
`ifdef SEQ_EDGE_CNT_EN
    ,
    .CNT_W(2)
`endif
  ) dut0 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus0.slave)
`ifdef SEQ_EDGE_CNT_EN
    ,
    .edge_cnt(ec0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    rst_n = 1'b0;
    #1;
    obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_dut1 got=%b exp=%b", obs, 5'b00001);
    end
    obs = {bus0.x_out, bus0.x_valid, bus0.busy, bus0.done, bus0.din_ready};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_dut0 got=%b exp=%b", obs, 5'b00001);
    end
`ifdef SEQ_EDGE_CNT_EN
    n_cmp++;
    if (ec1 !== 16'd0 || ec0 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_edge_cnt got=%0d/%0d exp=0/0", ec1, ec0);
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // 8'hA5 on dut1: eight data bits, one gap cycle, then done.
  task automatic test_basic();
    logic [7:0] w;
    logic [4:0] obs;
    logic [4:0] exp;
`ifdef SEQ_EDGE_CNT_EN
    logic [15:0] ec_start;
    ec_start = ec1;
`endif
    w = 8'hA5;
    bus1.din = w;
    bus1.din_valid = 1'b1;
    tick();
    bus1.din_valid = 1'b0;
    bus1.din = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      exp = {w[i], 4'b1100};
      obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL basic_bit%0d got=%b exp=%b", i, obs, exp);
      end
      tick();
    end
    obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
    n_cmp++;
    if (obs !== 5'b00100) begin
      n_fail++;
      $display("FAIL basic_gap got=%b exp=%b", obs, 5'b00100);
    end
    tick();
    obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
    n_cmp++;
    if (obs !== 5'b00011) begin
      n_fail++;
      $display("FAIL basic_done got=%b exp=%b", obs, 5'b00011);
    end
    tick();
    obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL basic_idle got=%b exp=%b", obs, 5'b00001);
    end
`ifdef SEQ_EDGE_CNT_EN
    n_cmp++;
    if (ec1 - ec_start !== 16'd4) begin
      n_fail++;
      $display("FAIL basic_edges got=%0d exp=4", ec1 - ec_start);
    end
`endif
  endtask

  // 8'hFF held valid while 8'h0F shifts: accepted only in the done cycle.
  task automatic test_back_to_back();
    logic [7:0] w;
    logic [4:0] obs;
    logic [4:0] exp;
`ifdef SEQ_EDGE_CNT_EN
    logic [15:0] ec_start;
    ec_start = ec1;
`endif
    w = 8'h0F;
    bus1.din = w;
    bus1.din_valid = 1'b1;
    tick();
    bus1.din = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      for (int i = 7; i >= 0; i--) begin
        exp = {w[i], 4'b1100};
        obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
        n_cmp++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL b2b_w%0d_bit%0d got=%b exp=%b", k, i, obs, exp);
        end
        tick();
      end
      obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
      n_cmp++;
      if (obs !== 5'b00100) begin
        n_fail++;
        $display("FAIL b2b_w%0d_gap got=%b exp=%b", k, obs, 5'b00100);
      end
      tick();
      obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
      n_cmp++;
      if (obs !== 5'b00011) begin
        n_fail++;
        $display("FAIL b2b_w%0d_done got=%b exp=%b", k, obs, 5'b00011);
      end
      tick();
      bus1.din_valid = 1'b0;
      w = 8'hFF;
    end
    obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL b2b_idle got=%b exp=%b", obs, 5'b00001);
    end
`ifdef SEQ_EDGE_CNT_EN
    n_cmp++;
    if (ec1 - ec_start !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_edges got=%0d exp=2", ec1 - ec_start);
    end
`endif
  endtask

  // Reset mid-word of 8'hC3, then 8'h81 must go out cleanly.
  task automatic test_reset_midword();
    logic [7:0] w;
    logic [4:0] obs;
    logic [4:0] exp;
    w = 8'hC3;
    bus1.din = w;
    bus1.din_valid = 1'b1;
    tick();
    bus1.din_valid = 1'b0;
    for (int i = 7; i >= 5; i--) begin
      exp = {w[i], 4'b1100};
      obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rstmid_bit%0d got=%b exp=%b", i, obs, exp);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL rstmid_clear got=%b exp=%b", obs, 5'b00001);
    end
`ifdef SEQ_EDGE_CNT_EN
    n_cmp++;
    if (ec1 !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_edge_clear got=%0d exp=0", ec1);
    end
`endif
    rst_n = 1'b1;
    tick();
    w = 8'h81;
    bus1.din = w;
    bus1.din_valid = 1'b1;
    tick();
    bus1.din_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      exp = {w[i], 4'b1100};
      obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rstmid_81_bit%0d got=%b exp=%b", i, obs, exp);
      end
      tick();
    end
    tick();
    obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
    n_cmp++;
    if (obs !== 5'b00011) begin
      n_fail++;
      $display("FAIL rstmid_81_done got=%b exp=%b", obs, 5'b00011);
    end
    tick();
`ifdef SEQ_EDGE_CNT_EN
    n_cmp++;
    if (ec1 !== 16'd2) begin
      n_fail++;
      $display("FAIL rstmid_81_edges got=%0d exp=2", ec1);
    end
`endif
  endtask

  // All-zero word: line stays 0 while valid, no falling edges.
  task automatic test_zero_word();
    logic [4:0] obs;
`ifdef SEQ_EDGE_CNT_EN
    logic [15:0] ec_start;
    ec_start = ec1;
`endif
    bus1.din = 8'h00;
    bus1.din_valid = 1'b1;
    tick();
    bus1.din_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      obs = {bus1.x_out, bus1.x_valid, bus1.busy, bus1.done, bus1.din_ready};
      n_cmp++;
      if (obs !== 5'b01100) begin
        n_fail++;
        $display("FAIL zero_bit%0d got=%b exp=%b", i, obs, 5'b01100);
      end
      tick();
    end
    tick();
    tick();
`ifdef SEQ_EDGE_CNT_EN
    n_cmp++;
    if (ec1 !== ec_start) begin
      n_fail++;
      $display("FAIL zero_edges got=%0d exp=%0d", ec1, ec_start);
    end
`endif
  endtask

  // dut0 (no gap): FF then FF accepted in the done cycle; busy low only there.
  task automatic test_no_gap();
    logic [4:0] obs;
    bus0.din = 8'hFF;
    bus0.din_valid = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      for (int i = 7; i >= 0; i--) begin
        obs = {bus0.x_out, bus0.x_valid, bus0.busy, bus0.done, bus0.din_ready};
        n_cmp++;
        if (obs !== 5'b11100) begin
          n_fail++;
          $display("FAIL nogap_w%0d_bit%0d got=%b exp=%b", k, i, obs, 5'b11100);
        end
        tick();
      end
      obs = {bus0.x_out, bus0.x_valid, bus0.busy, bus0.done, bus0.din_ready};
      n_cmp++;
      if (obs !== 5'b00011) begin
        n_fail++;
        $display("FAIL nogap_w%0d_done got=%b exp=%b", k, obs, 5'b00011);
      end
      tick();
      bus0.din_valid = 1'b0;
    end
    obs = {bus0.x_out, bus0.x_valid, bus0.busy, bus0.done, bus0.din_ready};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_fail++;
      $display("FAIL nogap_idle got=%b exp=%b", obs, 5'b00001);
    end
  endtask

  // dut0 with 2-bit counter: four words of 8'h80 give counts 1,2,3,3.
  task automatic test_saturate();
    logic [4:0] obs;
    logic [1:0] exp_ec;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus0.din = 8'h80;
      bus0.din_valid = 1'b1;
      tick();
      bus0.din_valid = 1'b0;
      repeat (8) tick();
      obs = {bus0.x_out, bus0.x_valid, bus0.busy, bus0.done, bus0.din_ready};
      n_cmp++;
      if (obs !== 5'b00011) begin
        n_fail++;
        $display("FAIL sat_w%0d_done got=%b exp=%b", k, obs, 5'b00011);
      end
      tick();
      exp_ec = (k < 3) ? 2'(k + 1) : 2'd3;
`ifdef SEQ_EDGE_CNT_EN
      n_cmp++;
      if (ec0 !== exp_ec) begin
        n_fail++;
        $display("FAIL sat_w%0d_edges got=%0d exp=%0d", k, ec0, exp_ec);
      end
`endif
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus1.din = 8'h00;
    bus1.din_valid = 1'b0;
    bus0.din = 8'h00;
    bus0.din_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_midword();
    test_zero_word();
    test_no_gap();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
